// File: rtl/conv_mix_ctrl_if.sv
// Bundle of handshake and bus signals between conv_mix_ctrl and its
// environment (layer scheduler, weight/feature SRAMs, conv_mix_6 datapath).
// master: the sequencer itself; slave: the surrounding system.
interface conv_mix_ctrl_if;
    logic       go;
    logic       layer;
    logic       busy;
    logic       layer_done;
    logic       w_rd_en;
    logic [8:0] w_rd_addr;
    logic       w_bit;
    logic       weight;
    logic [5:0] weight_en;
    logic       start;
    logic       state;
    logic       din_ready;
    logic       fm_rd_en;
    logic [9:0] fm_rd_addr;
    logic [5:0] mix_done;
    logic       err;

    modport master (
        input  go, layer, w_bit, din_ready, mix_done,
        output busy, layer_done, w_rd_en, w_rd_addr, weight, weight_en,
               start, state, fm_rd_en, fm_rd_addr, err
    );

    modport slave (
        output go, layer, w_bit, din_ready, mix_done,
        input  busy, layer_done, w_rd_en, w_rd_addr, weight, weight_en,
               start, state, fm_rd_en, fm_rd_addr, err
    );
endinterface

// File: rtl/conv_mix_ctrl.sv
// conv_mix_ctrl: per-layer sequencer for the 6-channel conv/ReLU/maxpool
// datapath. Loads 6x25 kernel bits serially, runs the layer with `start`
// held high while streaming feature-map addresses, then waits for all
// channels to report done.
// Optional watchdog: define CONV_MIX_CTRL_TIMEOUT_EN to bound RUN length
// and report overruns on `err`.
module conv_mix_ctrl #(
    parameter int KTAPS          = 25,
    parameter int NCH            = 6,
    parameter int IN_PIX_L0      = 784,
    parameter int IN_PIX_L1      = 144,
    parameter int W_BASE_L1      = 150,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic             clk,
    input  logic             rstn,
    conv_mix_ctrl_if.master  bus
);

    localparam logic [7:0] WCNT_LAST = 8'(NCH * KTAPS - 1);
    localparam logic [4:0] TAP_LAST  = 5'(KTAPS - 1);
    localparam logic [8:0] W_BASE1   = 9'(W_BASE_L1);
    localparam logic [9:0] PIX_L0    = 10'(IN_PIX_L0);
    localparam logic [9:0] PIX_L1    = 10'(IN_PIX_L1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_W    = 3'd1,
        S_LOAD_TAIL = 3'd2,
        S_RUN       = 3'd3,
        S_FINISH    = 3'd4
    } fsm_t;

    fsm_t       fsm_r;
    logic [7:0] wcnt_r;        // weight bit being issued this cycle
    logic [4:0] wtap_r;        // tap index within the issuing channel
    logic [2:0] wch_r;         // channel of the bit being issued
    logic [2:0] ch_r;          // channel of the bit returning from SRAM
    logic       rd_v_r;        // SRAM data valid this cycle
    logic [9:0] pcnt_r;        // feature pixels consumed so far
    logic       busy_r;
    logic       layer_done_r;
    logic       w_rd_en_r;
    logic [8:0] w_rd_addr_r;
    logic       start_r;
    logic       state_r;       // latched layer mode

    logic [9:0] in_pix_s;
    logic       fm_rd_en_s;
    logic [5:0] weight_en_s;

`ifdef CONV_MIX_CTRL_TIMEOUT_EN
    localparam logic [11:0] TO_LAST = 12'(TIMEOUT_CYCLES - 1);
    logic [11:0] wdog_r;
    logic        err_r;
`endif

    // Pixel budget for the latched layer mode
    always_comb begin
        in_pix_s = PIX_L0;
        if (state_r) begin
            in_pix_s = PIX_L1;
        end else begin
            in_pix_s = PIX_L0;
        end
    end

    // Feature read strobe: only in RUN, only while pixels remain
    always_comb begin
        fm_rd_en_s = 1'b0;
        if ((fsm_r == S_RUN) && bus.din_ready && (pcnt_r < in_pix_s)) begin
            fm_rd_en_s = 1'b1;
        end else begin
            fm_rd_en_s = 1'b0;
        end
    end

    // One-hot channel enable aligned with the returning weight bit
    always_comb begin
        weight_en_s = 6'b000000;
        if (rd_v_r) begin
            weight_en_s = 6'b000001 << ch_r;
        end else begin
            weight_en_s = 6'b000000;
        end
    end

    // Sequencer FSM, counters and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fsm_r        <= S_IDLE;
            wcnt_r       <= 8'd0;
            wtap_r       <= 5'd0;
            wch_r        <= 3'd0;
            ch_r         <= 3'd0;
            rd_v_r       <= 1'b0;
            pcnt_r       <= 10'd0;
            busy_r       <= 1'b0;
            layer_done_r <= 1'b0;
            w_rd_en_r    <= 1'b0;
            w_rd_addr_r  <= 9'd0;
            start_r      <= 1'b0;
            state_r      <= 1'b0;
`ifdef CONV_MIX_CTRL_TIMEOUT_EN
            wdog_r       <= 12'd0;
            err_r        <= 1'b0;
`endif
        end else begin
            // SRAM returns data one cycle after the read, so the valid
            // flag and channel index simply trail the issue side.
            rd_v_r       <= w_rd_en_r;
            ch_r         <= wch_r;
            layer_done_r <= 1'b0;
            case (fsm_r)
                S_IDLE: begin
                    if (bus.go) begin
                        state_r     <= bus.layer;
                        wcnt_r      <= 8'd0;
                        wtap_r      <= 5'd0;
                        wch_r       <= 3'd0;
                        pcnt_r      <= 10'd0;
                        w_rd_en_r   <= 1'b1;
                        w_rd_addr_r <= bus.layer ? W_BASE1 : 9'd0;
                        busy_r      <= 1'b1;
`ifdef CONV_MIX_CTRL_TIMEOUT_EN
                        err_r       <= 1'b0;
`endif
                        fsm_r       <= S_LOAD_W;
                    end
                end
                S_LOAD_W: begin
                    if (wcnt_r == WCNT_LAST) begin
                        w_rd_en_r <= 1'b0;
                        fsm_r     <= S_LOAD_TAIL;
                    end else begin
                        wcnt_r      <= wcnt_r + 8'd1;
                        w_rd_addr_r <= w_rd_addr_r + 9'd1;
                        if (wtap_r == TAP_LAST) begin
                            wtap_r <= 5'd0;
                            wch_r  <= wch_r + 3'd1;
                        end else begin
                            wtap_r <= wtap_r + 5'd1;
                        end
                    end
                end
                S_LOAD_TAIL: begin
                    // last weight bit is on the bus this cycle
                    start_r <= 1'b1;
`ifdef CONV_MIX_CTRL_TIMEOUT_EN
                    wdog_r  <= 12'd0;
`endif
                    fsm_r   <= S_RUN;
                end
                S_RUN: begin
                    if (fm_rd_en_s) begin
                        pcnt_r <= pcnt_r + 10'd1;
                    end
                    if (bus.mix_done == 6'h3F) begin
                        start_r      <= 1'b0;
                        layer_done_r <= 1'b1;
                        fsm_r        <= S_FINISH;
                    end
`ifdef CONV_MIX_CTRL_TIMEOUT_EN
                    else if (wdog_r == TO_LAST) begin
                        start_r      <= 1'b0;
                        layer_done_r <= 1'b1;
                        err_r        <= 1'b1;
                        fsm_r        <= S_FINISH;
                    end else begin
                        wdog_r <= wdog_r + 12'd1;
                    end
`endif
                end
                S_FINISH: begin
                    busy_r <= 1'b0;
                    fsm_r  <= S_IDLE;
                end
                default: begin
                    busy_r    <= 1'b0;
                    start_r   <= 1'b0;
                    w_rd_en_r <= 1'b0;
                    fsm_r     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.layer_done = layer_done_r;
    assign bus.w_rd_en    = w_rd_en_r;
    assign bus.w_rd_addr  = w_rd_addr_r;
    assign bus.weight     = bus.w_bit;
    assign bus.weight_en  = weight_en_s;
    assign bus.start      = start_r;
    assign bus.state      = state_r;
    assign bus.fm_rd_en   = fm_rd_en_s;
    assign bus.fm_rd_addr = pcnt_r;
`ifdef CONV_MIX_CTRL_TIMEOUT_EN
    assign bus.err        = err_r;
`else
    assign bus.err        = 1'b0;
`endif

endmodule

// File: doc/conv_mix_ctrl.md
Name: conv_mix_ctrl

Overview:
- Sequencer for the 6-channel conv/ReLU/maxpool datapath (`conv_mix_6`).
- Per layer, it does four things in order:
  - loads the 6×25 binary kernel bits serially;
  - raises `start` with the layer-mode `state` bit held steady;
  - streams feature-map read addresses whenever the datapath signals `din_ready`;
  - waits for the all-channel `done` before returning to idle.
- Sits between the top-level layer scheduler and `conv_mix_6` plus the weight/feature SRAMs.

Parameters:
- KTAPS, 25, kernel bits per channel (5×5).
- NCH, 6, parallel channels.
- IN_PIX_L0, 784, input pixels for layer mode 0 (28×28).
- IN_PIX_L1, 144, input pixels for layer mode 1 (12×12).
- W_BASE_L1, 150, weight-memory base address for layer mode 1 (layer 0 base is 0).
- TIMEOUT_CYCLES, 4095, watchdog limit (only used with the optional feature).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- go  in  1  single-cycle layer start request
- layer  in  1  layer mode; sampled when `go` is accepted
- busy  out  1  high in any state other than IDLE
- layer_done  out  1  one-cycle pulse at end of layer
- w_rd_en  out  1  weight SRAM read enable
- w_rd_addr  out  9  weight SRAM bit address
- w_bit  in  1  weight SRAM data, valid 1 cycle after `w_rd_en`
- weight  out  1  to datapath `weight`
- weight_en  out  6  to datapath `weight_en`, one-hot
- start  out  1  to datapath `start`
- state  out  1  to datapath `state`
- din_ready  in  1  from datapath; input pixel consumed this cycle
- fm_rd_en  out  1  feature SRAM read enable
- fm_rd_addr  out  10  feature SRAM pixel address
- mix_done  in  6  from datapath `done`
- err  out  1  watchdog error flag (always 0 without the optional feature)

Behaviour:
- Clock and reset: one clock `clk`; `rstn` is asynchronous, active-low.
- Reset values: every output is 0; FSM is in IDLE; all counters are 0.
- FSM states: IDLE → LOAD_W → LOAD_TAIL → RUN → FINISH → IDLE.
- IDLE:
  - `go`=1 latches `layer` into `state` (held constant until the next accepted `go`).
  - Clears the weight counter `wcnt` and the pixel counter.
  - Next state LOAD_W.
- LOAD_W:
  - `w_rd_en`=1.
  - `w_rd_addr` = base + `wcnt`, where base = 0 or W_BASE_L1.
  - `wcnt` counts 0..149 (NCH·KTAPS−1), one per cycle.
  - A registered copy of the read (`rd_v`, `ch` = wcnt/25 as a counter, not a divider) is kept one cycle.
  - `weight_en` = `rd_v` ? onehot(ch) : 0.
  - `weight` = `w_bit` (combinational), aligned with `weight_en`.
  - After `wcnt`=149 is issued, go to LOAD_TAIL.
- LOAD_TAIL:
  - One cycle that presents the last bit (channel 5, `weight_en`=6'b100000).
  - `w_rd_en`=0. Next state RUN.
- RUN:
  - `start`=1 throughout.
  - `fm_rd_en` = `din_ready` AND (pixel count < IN_PIX); IN_PIX selected by `state`.
  - `fm_rd_addr` = pixel count. The count increments on each cycle with `fm_rd_en`=1 and saturates at IN_PIX; no wrap.
  - When `mix_done`==6'h3F, go to FINISH.
  - A partial `mix_done` (not all ones) is ignored.
- FINISH:
  - `start`=0, `layer_done`=1 for exactly one cycle.
  - Next state IDLE.
- Total weight-load latency: 151 cycles from the cycle after `go` to the first cycle of `start`.
- `go` in any non-IDLE state is ignored; no queuing.
- `mix_done` outside RUN is ignored.
- `din_ready` while pixel count = IN_PIX gives `fm_rd_en`=0; `fm_rd_addr` holds at IN_PIX.
- Reset asserted mid-operation: immediate return to reset values. `start` and `weight_en` drop asynchronously.

Optional Feature:
- Macro: CONV_MIX_CTRL_TIMEOUT_EN.
- With the macro defined:
  - A 12-bit watchdog counts RUN cycles.
  - Reaching TIMEOUT_CYCLES forces FINISH with `layer_done`=1 and sets `err`=1.
  - `err` is sticky until the next accepted `go` or reset.
- Without the macro: no counter logic; `err` is tied to 0; RUN waits on `mix_done` indefinitely.

Test Plan:
- Reset, then `go`=1 with `layer`=0 → `busy`=1 next cycle.
  - `w_rd_addr` 0..149 on consecutive cycles.
  - `weight_en` 6'b000001 for 25 cycles, then 6'b000010 … 6'b100000.
  - `weight` equals the memory model's bits.
  - `start` rises on cycle 152.
- `layer`=1 → `state`=1; `w_rd_addr` 150..299.
  - Drive `din_ready` 200 cycles: `fm_rd_en` high exactly 144 times; `fm_rd_addr` stops at 144.
- In RUN, drive `mix_done`=6'h1F, then 6'h3F → no exit on 6'h1F.
  - On 6'h3F: `start`=0 next cycle, `layer_done` a single pulse, `busy`=0 the cycle after.
- `go` pulsed during LOAD_W and RUN → no effect on addresses, `state`, or the sequence.
- `rstn` low at `wcnt`=70 → all outputs 0 immediately.
  - A new `go` then restarts at address 0.
- With CONV_MIX_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=100, never assert `mix_done` → `layer_done` plus `err`=1 after 100 RUN cycles.
  - The next `go` clears `err`.
